bus_rr_arbit4: RTL and testbench

- Four-master round-robin bus arbiter with time-slice preemption; it sits in front of the shared bus and replaces the fixed two-master arbiter when more masters are attached.
- Grants exactly one master at a time (one-hot) and rotates priority fairly.
- A master holding the bus longer than MAX_HOLD cycles while others wait is forced off.

---
 rtl/bus_rr_arbit4.sv | 157 +++++++++++++++
 tb/tb_bus_rr_arbit4.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/bus_rr_arbit4.sv
// -----------------------------------------------------------------------------
// bus_rr_arbit4
//
// Four-master round-robin bus arbiter with time-slice preemption.
// Exactly one master owns the bus at a time. Priority rotates starting
// after the most recent owner. An owner that holds the bus for MAX_HOLD
// consecutive contended cycles is forced off in favour of the next
// requester. All outputs are registered, so there is no combinational path
// from req_i to any output. Requests are sampled at a clock edge and the
// grant is visible in the following cycle.
//
// Ports:
//   clk            in   rising-edge clock
//   reset_n        in   asynchronous, active-low reset
//   req_i[3:0]     in   request per master (bit i = master i)
//   grant_o[3:0]   out  registered one-hot grant, all-zero when idle
//   grant_valid_o  out  registered, 1 when any grant bit is set
//   grant_id_o     out  registered index of the current owner; holds the
//                       last owner while idle (this is also the RR pointer)
//   preempt_o      out  registered one-cycle pulse, asserted in the first
//                       cycle of the new owner after a time-slice preemption
//
// Parameters:
//   MAX_HOLD  maximum consecutive contended cycles for one owner (2..15)
//   CW        hold counter width, 2**CW > MAX_HOLD
// -----------------------------------------------------------------------------
module bus_rr_arbit4 #(
    parameter int MAX_HOLD = 8,
    parameter int CW       = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req_i,
    output logic [3:0] grant_o,
    output logic       grant_valid_o,
    output logic [1:0] grant_id_o,
    output logic       preempt_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    state_t        state_q,    state_d;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]    grant_id_q, grant_id_d;
    logic [3:0]    grant_q,    grant_d;
    logic          valid_q,    valid_d;
    logic          preempt_q,  preempt_d;

    logic [3:0]    owner_mask;
    logic [3:0]    other_req;
    logic [3:0]    next_onehot;

    // Round-robin search: first set bit of r in order from+1, from+2,
    // from+3, from. Iterating from the farthest offset down lets the
    // nearest candidate overwrite the result last.
    function automatic logic [1:0] rr_pick(input logic [3:0] r,
                                           input logic [1:0] from);
        logic [1:0] pick;
        logic [1:0] idx;
        pick = from;
        for (int k = 4; k >= 1; k--) begin
            idx = from + 2'(k);
            if (r[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

    // The registered grant_id doubles as the last owner (RR pointer).
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_decode
            assign owner_mask[gi]  = (grant_id_q == 2'(gi));
            assign next_onehot[gi] = (grant_id_d == 2'(gi));
        end
    endgenerate

    assign other_req = req_i & ~owner_mask;

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        hold_cnt_d = hold_cnt_q;
        preempt_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_i != 4'b0000) begin
                    state_d    = GRANT;
                    grant_id_d = rr_pick(req_i, grant_id_q);
                    hold_cnt_d = '0;
                end
            end

            GRANT: begin
                if (!req_i[grant_id_q]) begin
                    // Release: hand over in the same edge, or fall idle.
                    hold_cnt_d = '0;
                    if (other_req != 4'b0000) begin
                        grant_id_d = rr_pick(other_req, grant_id_q);
                    end else begin
                        state_d = IDLE;
                    end
                end else if (other_req != 4'b0000) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        // Time slice used up while others wait.
                        grant_id_d = rr_pick(other_req, grant_id_q);
                        hold_cnt_d = '0;
                        preempt_d  = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end else begin
                    // Uncontended cycles never count toward preemption.
                    hold_cnt_d = '0;
                end
            end

            default: begin
                state_d    = IDLE;
                hold_cnt_d = '0;
            end
        endcase

        valid_d = (state_d == GRANT);
        grant_d = valid_d ? next_onehot : 4'b0000;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            grant_id_q <= 2'd3;
            grant_q    <= 4'b0000;
            valid_q    <= 1'b0;
            preempt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            grant_id_q <= grant_id_d;
            grant_q    <= grant_d;
            valid_q    <= valid_d;
            preempt_q  <= preempt_d;
        end
    end

    assign grant_o       = grant_q;
    assign grant_valid_o = valid_q;
    assign grant_id_o    = grant_id_q;
    assign preempt_o     = preempt_q;

endmodule

// File: tb/tb_bus_rr_arbit4.sv
// -----------------------------------------------------------------------------
// tb_bus_rr_arbit4
//
// Directed bench for bus_rr_arbit4 (MAX_HOLD = 8). Each step drives req,
// pushes the expected grant/id/preempt onto a scoreboard queue, lets one
// rising edge pass and then pops and compares #1 after the edge.
// -----------------------------------------------------------------------------
module tb_bus_rr_arbit4;

    logic       clk;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       preempt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] grant;
        logic [1:0] id;
        logic       preempt;
    } exp_t;

    exp_t sb[$];

    bus_rr_arbit4 #(.MAX_HOLD(8), .CW(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_i         (req),
        .grant_o       (grant),
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id),
        .preempt_o     (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push_exp(input logic [3:0] g, input logic [1:0] id, input logic p);
        exp_t e;
        e.grant   = g;
        e.id      = id;
        e.preempt = p;
        sb.push_back(e);
    endtask

    task automatic check_pop(input string tag);
        exp_t e;
        logic exp_valid;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: scoreboard empty, got nothing, expected an entry", tag);
            return;
        end
        e = sb.pop_front();
        exp_valid = (e.grant != 4'b0000);

        checks++;
        assert (grant === e.grant) else begin
            errors++;
            $error("FAIL %s grant: got %b expected %b", tag, grant, e.grant);
        end
        checks++;
        assert (grant_valid === exp_valid) else begin
            errors++;
            $error("FAIL %s grant_valid: got %b expected %b", tag, grant_valid, exp_valid);
        end
        checks++;
        assert (grant_id === e.id) else begin
            errors++;
            $error("FAIL %s grant_id: got %0d expected %0d", tag, grant_id, e.id);
        end
        checks++;
        assert (preempt === e.preempt) else begin
            errors++;
            $error("FAIL %s preempt: got %b expected %b", tag, preempt, e.preempt);
        end
        checks++;
        assert ($onehot0(grant) && (grant_valid === (|grant))) else begin
            errors++;
            $error("FAIL %s invariant: got grant %b valid %b, expected one-hot/zero with matching valid",
                   tag, grant, grant_valid);
        end
    endtask

    // One clock step: drive req, record expectation, compare after the edge.
    task automatic step(input logic [3:0] r, input logic [3:0] g,
                        input logic [1:0] id, input logic p, input string tag);
        req = r;
        push_exp(g, id, p);
        @(posedge clk);
        #1;
        check_pop(tag);
        $display("step %-12s req=%b grant=%b valid=%b id=%0d preempt=%b",
                 tag, r, grant, grant_valid, grant_id, preempt);
    endtask

    initial begin
        logic [3:0] og;
        reset_n = 1'b0;
        req     = 4'b0000;

        // Reset values
        #12;
        push_exp(4'b0000, 2'd3, 1'b0);
        check_pop("reset");
        reset_n = 1'b1;

        step(4'b0000, 4'b0000, 2'd3, 1'b0, "idle");

        // All four requesting: 0,1,2,3,0 each for 8 cycles, preempt at rotation
        for (int r = 0; r < 5; r++) begin
            og = 4'b0001 << (r % 4);
            for (int c = 0; c < 8; c++) begin
                step(4'b1111, og, 2'(r % 4), (c == 0) && (r > 0), "rotate");
            end
        end

        // Owner 0 releases while 1 requests: handover to 1, no bubble
        step(4'b0010, 4'b0010, 2'd1, 1'b0, "handover");
        // 0010 -> 1001: RR from 1 picks 3 before 0
        step(4'b1001, 4'b1000, 2'd3, 1'b0, "rr_from_1");

        // Lone requester 2 for 20 cycles: never preempted
        for (int c = 0; c < 20; c++) begin
            step(4'b0100, 4'b0100, 2'd2, 1'b0, "alone");
        end

        // Contention from 0 starts now: hold counter was 0, so 8 cycles of 2
        for (int c = 0; c < 7; c++) begin
            step(4'b0101, 4'b0100, 2'd2, 1'b0, "contend");
        end
        step(4'b0101, 4'b0001, 2'd0, 1'b1, "slice_end");

        // Owner 0 plus req[2] for 7 more cycles, then 0 drops on cycle 8
        for (int c = 0; c < 7; c++) begin
            step(4'b0101, 4'b0001, 2'd0, 1'b0, "hold0");
        end
        step(4'b0100, 4'b0100, 2'd2, 1'b0, "sat_release");

        // All drop: idle, id holds last owner; then RR from last owner
        step(4'b0000, 4'b0000, 2'd2, 1'b0, "drop_all");
        step(4'b0000, 4'b0000, 2'd2, 1'b0, "idle_hold");
        step(4'b1111, 4'b1000, 2'd3, 1'b0, "wake");
        step(4'b1111, 4'b1000, 2'd3, 1'b0, "wake_hold");

        // Asynchronous reset mid-grant (grant = 1000)
        reset_n = 1'b0;
        #2;
        push_exp(4'b0000, 2'd3, 1'b0);
        check_pop("async_rst");
        step(4'b1010, 4'b0000, 2'd3, 1'b0, "in_reset");
        reset_n = 1'b1;
        step(4'b1010, 4'b0010, 2'd1, 1'b0, "post_reset");

        // Release to idle from owner 1, then RR resumes after 1
        step(4'b0000, 4'b0000, 2'd1, 1'b0, "idle_after1");
        step(4'b1111, 4'b0100, 2'd2, 1'b0, "wake_after1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
